// File: rtl/mlp_top.sv
// ---------------------------------------------------------------------------
// mlp_top
//
// Class-scoring and output stage of the MLP classifier. A start request
// latches three 10-bit indices. The block then runs two sequential passes
// over the 387 classes, one class per clock:
//   SCAN  : generates each class logit and tracks the arg-max.
//   WRITE : regenerates each logit and stores an 8-bit exponential-style
//           score (0xFF >> distance-from-max) into the packed output bus.
// When the WRITE pass finishes, `done` rises and `predicted_index` carries
// the arg-max class. Both stay put until reset or the next start.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high
//   M_index          in   10  slope index, sampled only on the start edge
//   N_index          in   10  offset index, sampled only on the start edge
//   K_index          in   10  offset index, sampled only on the start edge
//   read_enable      in   1   start request, honoured in IDLE and DONE
//   softmax_out      out  DATA_WIDTH*387, class c score at [8c+7:8c]
//   done             out  1   level, high while the results are valid
//   predicted_index  out  9   arg-max class, 0..386
// ---------------------------------------------------------------------------
module mlp_top #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                M_index,
  input  logic [9:0]                N_index,
  input  logic [9:0]                K_index,
  input  logic                      read_enable,
  output logic [DATA_WIDTH*387-1:0] softmax_out,
  output logic                      done,
  output logic [8:0]                predicted_index
);

  localparam logic [8:0] LAST_CLASS = 9'd386;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    DONE
  } state_t;

  state_t     state;
  logic [8:0] c;
  logic [9:0] m_lat;
  logic [9:0] n_lat;
  logic [9:0] k_lat;
  logic [7:0] max_val;
  logic [8:0] argmax;
  logic [7:0] logit;
  logic [7:0] diff;

  // Score saturates to zero once the logit is 8 or more below the maximum;
  // otherwise it is a right shift of all-ones by the distance.
  function automatic logic [7:0] calc_score(input logic [7:0] d);
    if (d >= 8'd8) begin
      return 8'h00;
    end
    return 8'hFF >> d[2:0];
  endfunction

  // The product is formed at 21 bits so nothing is lost before the modulo
  // 256; only the low byte is kept as the logit.
  always_comb begin
    logit = 8'(21'(c) * (21'(m_lat) + 21'd1) + 21'(n_lat) + 21'(k_lat));
  end

  // In WRITE the maximum is final, so this difference is never negative.
  always_comb begin
    diff = max_val - logit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      c               <= '0;
      m_lat           <= '0;
      n_lat           <= '0;
      k_lat           <= '0;
      max_val         <= '0;
      argmax          <= '0;
      done            <= 1'b0;
      predicted_index <= '0;
      softmax_out     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A start from DONE behaves exactly like one from IDLE; `done`
          // drops on the same edge.
          if (read_enable) begin
            m_lat   <= M_index;
            n_lat   <= N_index;
            k_lat   <= K_index;
            max_val <= '0;
            argmax  <= '0;
            c       <= '0;
            done    <= 1'b0;
            state   <= SCAN;
          end
        end

        SCAN: begin
          // Strictly-greater compare keeps the lowest index on ties; class 0
          // always loads so the first logit seeds the running maximum.
          if ((c == 9'd0) || (logit > max_val)) begin
            max_val <= logit;
            argmax  <= c;
          end
          if (c == LAST_CLASS) begin
            c     <= '0;
            state <= WRITE;
          end else begin
            c <= c + 9'd1;
          end
        end

        WRITE: begin
          softmax_out[c*DATA_WIDTH +: DATA_WIDTH] <= calc_score(diff);
          if (c == LAST_CLASS) begin
            c               <= '0;
            predicted_index <= argmax;
            done            <= 1'b1;
            state           <= DONE;
          end else begin
            c <= c + 9'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_top.sv
module tb_mlp_top;

  localparam int NC      = 387;
  localparam int OUT_W   = 8 * NC;
  localparam int LATENCY = 774;

  logic             clk = 1'b0;
  logic             reset;
  logic [9:0]       M_index;
  logic [9:0]       N_index;
  logic [9:0]       K_index;
  logic             read_enable;
  logic [OUT_W-1:0] softmax_out;
  logic             done;
  logic [8:0]       predicted_index;

  mlp_top #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .M_index         (M_index),
    .N_index         (N_index),
    .K_index         (K_index),
    .read_enable     (read_enable),
    .softmax_out     (softmax_out),
    .done            (done),
    .predicted_index (predicted_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] out;
    int               pred;
    int               start_edge;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [7:0] exp);
    chk(name, {24'd0, softmax_out[idx*8 +: 8]}, {24'd0, exp});
  endtask

  // Reference model: logits, first maximum, then shifted-ones score per class.
  task automatic ref_model(input logic [9:0] m, input logic [9:0] n, input logic [9:0] k,
                           output logic [OUT_W-1:0] out, output int pred);
    int lg[NC];
    int mx;
    int d;
    int s;
    mx   = -1;
    pred = 0;
    for (int i = 0; i < NC; i++) begin
      lg[i] = (i * (int'(m) + 1) + int'(n) + int'(k)) % 256;
      if (lg[i] > mx) begin
        mx   = lg[i];
        pred = i;
      end
    end
    out = '0;
    for (int i = 0; i < NC; i++) begin
      d = mx - lg[i];
      s = (d >= 8) ? 0 : (255 >> d);
      out[i*8 +: 8] = 8'(s);
    end
  endtask

  // Monitor: on each rising `done`, pop the expected run and compare.
  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done rose with no run pending (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("predicted_index", {23'd0, predicted_index}, e.pred);
        chk("latency", cyc - e.start_edge, LATENCY);
        checks++;
        if (softmax_out !== e.out) begin
          errors++;
          bad = -1;
          for (int i = NC - 1; i >= 0; i--)
            if (softmax_out[i*8 +: 8] !== e.out[i*8 +: 8]) bad = i;
          $display("FAIL softmax_out: first bad byte %0d got 0x%0h expected 0x%0h",
                   bad, softmax_out[bad*8 +: 8], e.out[bad*8 +: 8]);
        end
      end
    end
    prev_done = done;
  end

  // Issue a start on the next edge; keep read_enable high for `hold` edges.
  task automatic start_run(input logic [9:0] m, input logic [9:0] n, input logic [9:0] k,
                           input int hold);
    exp_t e;
    @(negedge clk);
    M_index     = m;
    N_index     = n;
    K_index     = k;
    read_enable = 1'b1;
    ref_model(m, n, k, e.out, e.pred);
    e.start_edge = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    chk("done_clears_on_start", {31'd0, done}, 0);
    for (int i = 1; i < hold; i++) @(negedge clk);
    read_enable = 1'b0;
  endtask

  // Bounded wait for `done`; optional input noise while the run is busy.
  task automatic wait_done(input bit noise);
    for (int i = 0; i < LATENCY + 100; i++) begin
      if (done) break;
      if (noise && i < 700) begin
        read_enable = 1'($urandom_range(0, 1));
        M_index     = 10'($urandom);
        N_index     = 10'($urandom);
        K_index     = 10'($urandom);
      end else begin
        read_enable = 1'b0;
      end
      @(negedge clk);
    end
    read_enable = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done still 0 after %0d cycles", LATENCY + 100);
    end
  endtask

  initial begin
    reset       = 1'b1;
    read_enable = 1'b0;
    M_index     = '0;
    N_index     = '0;
    K_index     = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_pred", {23'd0, predicted_index}, 0);
    chk("reset_out_zero", {31'd0, |softmax_out}, 0);
    reset = 1'b0;

    // M=N=K=0
    start_run(10'd0, 10'd0, 10'd0, 1);
    wait_done(1'b0);
    chk("s1_pred", {23'd0, predicted_index}, 255);
    chk_byte("s1_b0", 0, 8'h00);
    chk_byte("s1_b255", 255, 8'hFF);
    chk_byte("s1_b254", 254, 8'h7F);
    chk_byte("s1_b253", 253, 8'h3F);
    chk_byte("s1_b247", 247, 8'h00);

    // M=1: tie rule picks 127
    start_run(10'd1, 10'd0, 10'd0, 1);
    wait_done(1'b0);
    chk("s2_pred", {23'd0, predicted_index}, 127);
    chk_byte("s2_b127", 127, 8'hFF);
    chk_byte("s2_b255", 255, 8'hFF);
    chk_byte("s2_b383", 383, 8'hFF);
    chk_byte("s2_b126", 126, 8'h3F);
    chk_byte("s2_b128", 128, 8'h00);

    // M=0, N=10, K=20
    start_run(10'd0, 10'd10, 10'd20, 1);
    wait_done(1'b0);
    chk("s3_pred", {23'd0, predicted_index}, 225);
    chk_byte("s3_b225", 225, 8'hFF);
    chk_byte("s3_b224", 224, 8'h7F);
    chk_byte("s3_b226", 226, 8'h00);

    // Indices change two cycles after start: must be ignored
    start_run(10'd0, 10'd0, 10'd0, 1);
    @(negedge clk);
    M_index = 10'd100;
    N_index = 10'd200;
    K_index = 10'd300;
    wait_done(1'b0);
    chk("s4_pred", {23'd0, predicted_index}, 255);
    chk_byte("s4_b254", 254, 8'h7F);

    // Reset mid-SCAN
    start_run(10'd5, 10'd7, 10'd9, 1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_done", {31'd0, done}, 0);
    chk("midreset_out_zero", {31'd0, |softmax_out}, 0);
    chk("midreset_pred", {23'd0, predicted_index}, 0);
    sb_q.delete();
    reset = 1'b0;
    start_run(10'd0, 10'd0, 10'd0, 1);
    wait_done(1'b0);

    // Restart straight from DONE with read_enable held for several edges
    start_run(10'd1, 10'd0, 10'd0, 4);
    wait_done(1'b0);
    chk("s6_pred", {23'd0, predicted_index}, 127);
    chk_byte("s6_b126", 126, 8'h3F);

    // Randomised runs with noise on the inputs while busy
    for (int r = 0; r < 5; r++) begin
      start_run(10'($urandom), 10'($urandom), 10'($urandom), 1);
      wait_done(1'b1);
    end

    // Outputs hold in DONE with read_enable low
    repeat (5) @(negedge clk);
    chk("done_holds", {31'd0, done}, 1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
